// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle RV32I datapath: sequences fetch/decode/execute/memory/writeback.
// Optional JAL state is compiled in with `define JAL_SUPPORT_EN.
module multicycle_main_control #(
    parameter int unsigned INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 PCWriteCond,
    output logic                 IorD,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           MemtoReg,
    output logic [1:0]           ALUSrcB,
    output logic                 PCSrc,
    output logic [1:0]           ALUOp,
    output logic                 illegal_op,
    output logic [3:0]           state_out,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8
`ifdef JAL_SUPPORT_EN
        ,JAL     = 4'd9
`endif
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
`ifdef JAL_SUPPORT_EN
    localparam logic [6:0] OP_JAL = 7'b1101111;
`endif

    state_t state;
    logic   op_legal;

    always_comb begin
        case (opcode)
            OP_LW, OP_SW, OP_R, OP_BEQ: op_legal = 1'b1;
`ifdef JAL_SUPPORT_EN
            OP_JAL:                     op_legal = 1'b1;
`endif
            default:                    op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            instret <= '0;
        end else begin
            case (state)
                FETCH:    if (mem_ready) state <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_R:         state <= EXECUTE;
                        OP_BEQ:       state <= BRANCH;
`ifdef JAL_SUPPORT_EN
                        OP_JAL:       state <= JAL;
`endif
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR:   state <= (opcode == OP_LW) ? MEMREAD : MEMWRITE;
                MEMREAD:  if (mem_ready) state <= MEMWB;
                MEMWRITE: begin
                    if (mem_ready) begin
                        state   <= FETCH;
                        instret <= instret + INSTRET_W'(1);
                    end
                end
                EXECUTE:  state <= ALUWB;
                MEMWB, ALUWB, BRANCH
`ifdef JAL_SUPPORT_EN
                , JAL
`endif
                : begin
                    state   <= FETCH;
                    instret <= instret + INSTRET_W'(1);
                end
                default:  state <= FETCH;
            endcase
        end
    end

    // Moore decode; only FETCH's IRWrite/PCWrite depend on mem_ready, and reset blanks everything.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        MemtoReg    = 2'b00;
        ALUSrcB     = 2'b00;
        PCSrc       = 1'b0;
        ALUOp       = 2'b00;
        illegal_op  = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                DECODE: begin
                    ALUSrcB    = 2'b10;
                    illegal_op = ~op_legal;
                end
                MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                MEMREAD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 2'b01;
                end
                MEMWRITE: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                ALUWB:    RegWrite = 1'b1;
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSrc       = 1'b1;
                end
`ifdef JAL_SUPPORT_EN
                JAL: begin
                    PCWrite  = 1'b1;
                    PCSrc    = 1'b1;
                    RegWrite = 1'b1;
                    MemtoReg = 2'b10;
                end
`endif
                default: ;
            endcase
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: per-cycle expected state/controls/instret
// are queued as each step is driven and popped for comparison mid-cycle.
module tb_multicycle_main_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]  MemtoReg, ALUSrcB, ALUOp;
    logic        PCSrc, illegal_op;
    logic [3:0]  state_out;
    logic [31:0] instret;

    multicycle_main_control #(.INSTRET_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUOp(ALUOp),
        .illegal_op(illegal_op), .state_out(state_out), .instret(instret)
    );

    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,RegWrite,ALUSrcA,MemtoReg,ALUSrcB,PCSrc,ALUOp,illegal_op}
    logic [15:0] ctrl;
    assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA,
                   MemtoReg, ALUSrcB, PCSrc, ALUOp, illegal_op};

    localparam logic [15:0] C_ZERO       = 16'b0000_0000_00_00_0_00_0;
    localparam logic [15:0] C_FETCH_WAIT = 16'b0001_0000_00_01_0_00_0;
    localparam logic [15:0] C_FETCH_GO   = 16'b1001_0100_00_01_0_00_0;
    localparam logic [15:0] C_DECODE     = 16'b0000_0000_00_10_0_00_0;
    localparam logic [15:0] C_DECODE_ILL = 16'b0000_0000_00_10_0_00_1;
    localparam logic [15:0] C_MEMADR     = 16'b0000_0001_00_10_0_00_0;
    localparam logic [15:0] C_MEMREAD    = 16'b0011_0000_00_00_0_00_0;
    localparam logic [15:0] C_MEMWB      = 16'b0000_0010_01_00_0_00_0;
    localparam logic [15:0] C_MEMWRITE   = 16'b0010_1000_00_00_0_00_0;
    localparam logic [15:0] C_EXECUTE    = 16'b0000_0001_00_00_0_10_0;
    localparam logic [15:0] C_ALUWB      = 16'b0000_0010_00_00_0_00_0;
    localparam logic [15:0] C_BRANCH     = 16'b0100_0001_00_00_1_01_0;
    localparam logic [15:0] C_JAL        = 16'b1000_0010_10_00_1_00_0;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic [31:0] ir;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    task automatic step(input logic rst, input logic mr, input logic [6:0] op, input string tag,
                        input logic [3:0] st, input logic [15:0] c, input logic [31:0] ir);
        exp_t e;
        exp_t got;
        reset     = rst;
        mem_ready = mr;
        opcode    = op;
        e.tag = tag; e.st = st; e.ctrl = c; e.ir = ir;
        sb.push_back(e);
        #1;
        got = sb.pop_front();
        checks++;
        assert (state_out === got.st) else begin
            errors++;
            $error("FAIL %s state observed=%0d expected=%0d", got.tag, state_out, got.st);
        end
        checks++;
        assert (ctrl === got.ctrl) else begin
            errors++;
            $error("FAIL %s ctrl observed=%b expected=%b", got.tag, ctrl, got.ctrl);
        end
        checks++;
        assert (instret === got.ir) else begin
            errors++;
            $error("FAIL %s instret observed=%0d expected=%0d", got.tag, instret, got.ir);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b0; opcode = OP_R;
        @(negedge clk);
        step(1, 1, OP_R, "reset_hold", 4'd0, C_ZERO, 0);

        // R-type with one fetch stall
        step(0, 0, OP_R, "r_fetch_wait", 4'd0, C_FETCH_WAIT, 0);
        step(0, 1, OP_R, "r_fetch", 4'd0, C_FETCH_GO, 0);
        step(0, 1, OP_R, "r_decode", 4'd1, C_DECODE, 0);
        step(0, 1, OP_R, "r_execute", 4'd6, C_EXECUTE, 0);
        step(0, 1, OP_R, "r_aluwb", 4'd7, C_ALUWB, 0);

        // lw with two stall cycles in MEMREAD
        step(0, 1, OP_LW, "lw_fetch", 4'd0, C_FETCH_GO, 1);
        step(0, 1, OP_LW, "lw_decode", 4'd1, C_DECODE, 1);
        step(0, 1, OP_LW, "lw_memadr", 4'd2, C_MEMADR, 1);
        step(0, 0, OP_LW, "lw_memread0", 4'd3, C_MEMREAD, 1);
        step(0, 0, OP_LW, "lw_memread1", 4'd3, C_MEMREAD, 1);
        step(0, 1, OP_LW, "lw_memread2", 4'd3, C_MEMREAD, 1);
        step(0, 1, OP_LW, "lw_memwb", 4'd4, C_MEMWB, 1);

        // sw with one stall cycle in MEMWRITE
        step(0, 1, OP_SW, "sw_fetch", 4'd0, C_FETCH_GO, 2);
        step(0, 1, OP_SW, "sw_decode", 4'd1, C_DECODE, 2);
        step(0, 1, OP_SW, "sw_memadr", 4'd2, C_MEMADR, 2);
        step(0, 0, OP_SW, "sw_memwrite_wait", 4'd5, C_MEMWRITE, 2);
        step(0, 1, OP_SW, "sw_memwrite", 4'd5, C_MEMWRITE, 2);

        // beq
        step(0, 1, OP_BEQ, "beq_fetch", 4'd0, C_FETCH_GO, 3);
        step(0, 1, OP_BEQ, "beq_decode", 4'd1, C_DECODE, 3);
        step(0, 1, OP_BEQ, "beq_branch", 4'd8, C_BRANCH, 3);

        // illegal opcode: pulse only in DECODE, no retirement
        step(0, 1, OP_BAD, "ill_fetch", 4'd0, C_FETCH_GO, 4);
        step(0, 1, OP_BAD, "ill_decode", 4'd1, C_DECODE_ILL, 4);

        // jal
        step(0, 1, OP_JAL, "jal_fetch", 4'd0, C_FETCH_GO, 4);
`ifdef JAL_SUPPORT_EN
        step(0, 1, OP_JAL, "jal_decode", 4'd1, C_DECODE, 4);
        step(0, 1, OP_JAL, "jal_jal", 4'd9, C_JAL, 4);
        step(0, 1, OP_LW, "post_jal_fetch", 4'd0, C_FETCH_GO, 5);
`else
        step(0, 1, OP_JAL, "jal_decode_ill", 4'd1, C_DECODE_ILL, 4);
        step(0, 1, OP_LW, "post_jal_fetch", 4'd0, C_FETCH_GO, 4);
`endif

        // reset during a stalled MEMREAD
        step(0, 1, OP_LW, "rlw_decode", 4'd1, C_DECODE, `ifdef JAL_SUPPORT_EN 5 `else 4 `endif);
        step(0, 1, OP_LW, "rlw_memadr", 4'd2, C_MEMADR, `ifdef JAL_SUPPORT_EN 5 `else 4 `endif);
        step(0, 0, OP_LW, "rlw_memread", 4'd3, C_MEMREAD, `ifdef JAL_SUPPORT_EN 5 `else 4 `endif);
        step(1, 0, OP_LW, "rlw_reset", 4'd3, C_ZERO, `ifdef JAL_SUPPORT_EN 5 `else 4 `endif);
        step(0, 1, OP_R, "after_reset_fetch", 4'd0, C_FETCH_GO, 0);
        step(0, 1, OP_R, "after_reset_decode", 4'd1, C_DECODE, 0);
        step(0, 1, OP_R, "after_reset_execute", 4'd6, C_EXECUTE, 0);
        step(0, 1, OP_R, "after_reset_aluwb", 4'd7, C_ALUWB, 0);
        step(0, 1, OP_R, "after_reset_final", 4'd0, C_FETCH_GO, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
